// File: rtl/native_out_port.sv
// Video timing generator and FWFT pixel output stage for a native video sink.
// Optional: NATIVE_OUT_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module native_out_port #(
  parameter int   DSIZE    = 24,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic [15:0]      hactive,
  input  logic [15:0]      hfp,
  input  logic [15:0]      hsync_w,
  input  logic [15:0]      hbp,
  input  logic [15:0]      vactive,
  input  logic [15:0]      vfp,
  input  logic [15:0]      vsync_w,
  input  logic [15:0]      vbp,
  input  logic [DSIZE-1:0] idata,
  input  logic             idata_vld,
  output logic             idata_rd,
  output logic             falign,
  output logic             underflow,
`ifdef NATIVE_OUT_UNDERFLOW_CNT_EN
  output logic [15:0]      underflow_cnt,
`endif
  output logic             vsync,
  output logic             hsync,
  output logic             de,
  output logic [DSIZE-1:0] odata
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  state_t state_nx;
  logic   load;

  logic [15:0] s_hact;
  logic [15:0] s_hfp;
  logic [15:0] s_hsw;
  logic [15:0] s_hbp;
  logic [15:0] s_vact;
  logic [15:0] s_vfp;
  logic [15:0] s_vsw;
  logic [15:0] s_vbp;

  logic [16:0] hcnt;
  logic [16:0] vcnt;

  logic [16:0] in_htot;
  logic [16:0] in_vtot;
  logic        in_ok;
  logic [16:0] htot;
  logic [16:0] vtot;
  logic        h_last;
  logic        v_last;
  logic        f_last;
  logic        f_first;
  logic        run;

  logic [17:0] h_a0;
  logic [17:0] h_a1;
  logic [17:0] v_a0;
  logic [17:0] v_a1;
  logic        hs_i;
  logic        vs_i;
  logic        de_i;
  logic        uf_set;

  assign in_htot = {1'b0, hsync_w} + {1'b0, hbp}
                 + {1'b0, hactive} + {1'b0, hfp};
  assign in_vtot = {1'b0, vsync_w} + {1'b0, vbp}
                 + {1'b0, vactive} + {1'b0, vfp};
  assign in_ok   = (in_htot >= 17'd2) && (in_vtot >= 17'd1);

  assign htot = {1'b0, s_hsw} + {1'b0, s_hbp}
              + {1'b0, s_hact} + {1'b0, s_hfp};
  assign vtot = {1'b0, s_vsw} + {1'b0, s_vbp}
              + {1'b0, s_vact} + {1'b0, s_vfp};

  assign run     = (state == RUN);
  assign h_last  = (hcnt == htot - 17'd1);
  assign v_last  = (vcnt == vtot - 17'd1);
  assign f_last  = h_last && v_last;
  assign f_first = run && (hcnt == '0) && (vcnt == '0);

  // Active-window bounds are one bit wider so the sums cannot wrap.
  assign h_a0 = {2'b0, s_hsw} + {2'b0, s_hbp};
  assign h_a1 = h_a0 + {2'b0, s_hact};
  assign v_a0 = {2'b0, s_vsw} + {2'b0, s_vbp};
  assign v_a1 = v_a0 + {2'b0, s_vact};

  assign hs_i = hcnt < {1'b0, s_hsw};
  assign vs_i = vcnt < {1'b0, s_vsw};
  assign de_i = ({1'b0, hcnt} >= h_a0) && ({1'b0, hcnt} < h_a1)
             && ({1'b0, vcnt} >= v_a0) && ({1'b0, vcnt} < v_a1);

  // Pops track the counters directly so the FIFO head lines up with odata.
  assign idata_rd = de_i && run;
  assign uf_set   = run && de_i && !idata_vld;

  // State register.
  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Start, stop and timing re-latch only at frame boundaries.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && in_ok) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (f_last) begin
          if (enable && in_ok) load     = 1'b1;
          else                 state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shadow timing registers, updated only when a new frame starts.
  always_ff @(posedge clock) begin
    if (rst) begin
      s_hact <= '0;
      s_hfp  <= '0;
      s_hsw  <= '0;
      s_hbp  <= '0;
      s_vact <= '0;
      s_vfp  <= '0;
      s_vsw  <= '0;
      s_vbp  <= '0;
    end else if (load) begin
      s_hact <= hactive;
      s_hfp  <= hfp;
      s_hsw  <= hsync_w;
      s_hbp  <= hbp;
      s_vact <= vactive;
      s_vfp  <= vfp;
      s_vsw  <= vsync_w;
      s_vbp  <= vbp;
    end
  end

  // Raster counters; held at zero whenever a frame is not in progress.
  always_ff @(posedge clock) begin
    if (rst || load || !run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + 17'd1;
    end else begin
      hcnt <= hcnt + 17'd1;
    end
  end

  // Registered video outputs, one clock behind the counters.
  always_ff @(posedge clock) begin
    if (rst) begin
      vsync     <= ~SYNC_POL;
      hsync     <= ~SYNC_POL;
      de        <= 1'b0;
      odata     <= '0;
      falign    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      vsync     <= (run && vs_i) ? SYNC_POL : ~SYNC_POL;
      hsync     <= (run && hs_i) ? SYNC_POL : ~SYNC_POL;
      de        <= run && de_i;
      odata     <= (run && de_i && idata_vld) ? idata : '0;
      falign    <= f_first;
      underflow <= uf_set || (underflow && !f_first);
    end
  end

`ifdef NATIVE_OUT_UNDERFLOW_CNT_EN
  // Saturating count of starved pixels; only reset clears it.
  always_ff @(posedge clock) begin
    if (rst)
      underflow_cnt <= '0;
    else if (uf_set && underflow_cnt != 16'hFFFF)
      underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_native_out_port.sv
// Randomized bench for native_out_port against a position-in-frame model.
// Model derives every output from (frame position, latched timing) arithmetic.
module tb_native_out_port;

  localparam int   DSIZE = 24;
  localparam logic POL   = 1'b1;

  typedef struct {
    int hsw, hbp, ha, hfp, vsw, vbp, va, vfp;
  } cfg_t;

  logic             clock;
  logic             rst;
  logic             enable;
  logic [DSIZE-1:0] idata;
  logic             idata_vld;
  logic             idata_rd;
  logic             falign;
  logic             underflow;
  logic             vsync;
  logic             hsync;
  logic             de;
  logic [DSIZE-1:0] odata;
`ifdef NATIVE_OUT_UNDERFLOW_CNT_EN
  logic [15:0]      underflow_cnt;
`endif

  cfg_t in_cfg;

  native_out_port #(.DSIZE(DSIZE), .SYNC_POL(POL)) dut (
    .clock     (clock),
    .rst       (rst),
    .enable    (enable),
    .hactive   (16'(in_cfg.ha)),
    .hfp       (16'(in_cfg.hfp)),
    .hsync_w   (16'(in_cfg.hsw)),
    .hbp       (16'(in_cfg.hbp)),
    .vactive   (16'(in_cfg.va)),
    .vfp       (16'(in_cfg.vfp)),
    .vsync_w   (16'(in_cfg.vsw)),
    .vbp       (16'(in_cfg.vbp)),
    .idata     (idata),
    .idata_vld (idata_vld),
    .idata_rd  (idata_rd),
    .falign    (falign),
    .underflow (underflow),
`ifdef NATIVE_OUT_UNDERFLOW_CNT_EN
    .underflow_cnt (underflow_cnt),
`endif
    .vsync     (vsync),
    .hsync     (hsync),
    .de        (de),
    .odata     (odata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_run  = 0;
  int n_fail = 0;

  bit   m_run;
  int   m_p;
  cfg_t m_cfg;
  bit   m_uf;
  int   m_cnt;

  logic             rd_seen;
  logic             exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf;
  logic [DSIZE-1:0] exp_od;

  function automatic int tot_h(cfg_t c);
    return c.hsw + c.hbp + c.ha + c.hfp;
  endfunction

  function automatic int tot_v(cfg_t c);
    return c.vsw + c.vbp + c.va + c.vfp;
  endfunction

  function automatic bit legal(cfg_t c);
    return tot_h(c) >= 2 && tot_v(c) >= 1;
  endfunction

  function automatic cfg_t t1_cfg();
    cfg_t c;
    c.hsw = 2; c.hbp = 1; c.ha = 4; c.hfp = 1;
    c.vsw = 1; c.vbp = 1; c.va = 3; c.vfp = 1;
    return c;
  endfunction

  // One clock of DUT and model; leaves expectations in exp_*.
  task automatic step(input logic r, input logic en, input logic v);
    int  ht, vt, h, ln;
    bit  hs, vs, dei;
    rst       = r;
    enable    = en;
    idata_vld = v;
    idata     = DSIZE'($urandom);
    @(negedge clock);
    rd_seen = idata_rd;
    hs = 0; vs = 0; dei = 0;
    ht = tot_h(m_cfg);
    vt = tot_v(m_cfg);
    if (m_run) begin
      h   = m_p % ht;
      ln  = m_p / ht;
      hs  = h < m_cfg.hsw;
      vs  = ln < m_cfg.vsw;
      dei = h >= m_cfg.hsw + m_cfg.hbp
         && h < m_cfg.hsw + m_cfg.hbp + m_cfg.ha
         && ln >= m_cfg.vsw + m_cfg.vbp
         && ln < m_cfg.vsw + m_cfg.vbp + m_cfg.va;
    end
    exp_rd = dei;
    exp_vs = vs ? POL : ~POL;
    exp_hs = hs ? POL : ~POL;
    exp_de = dei;
    exp_fa = m_run && m_p == 0;
    exp_od = (dei && v) ? idata : '0;
    if (m_run && m_p == 0) m_uf = 0;
    if (dei && !v) begin
      m_uf = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (r) begin
      m_run = 0; m_p = 0; m_uf = 0; m_cnt = 0;
      exp_vs = ~POL; exp_hs = ~POL; exp_de = 0;
      exp_fa = 0; exp_od = '0;
    end else if (!m_run) begin
      if (en && legal(in_cfg)) begin
        m_run = 1; m_p = 0; m_cfg = in_cfg;
      end
    end else if (m_p == ht * vt - 1) begin
      if (en && legal(in_cfg)) begin
        m_cfg = in_cfg; m_p = 0;
      end else begin
        m_run = 0;
      end
    end else begin
      m_p++;
    end
    exp_uf = m_uf;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    in_cfg = t1_cfg();
    step(1, 0, 1);
    n_run++;
    if ({vsync, hsync, de, falign, underflow, odata} !==
        {~POL, ~POL, 1'b0, 1'b0, 1'b0, {DSIZE{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset got %b_%h want %b_0", {vsync, hsync, de, falign, underflow}, odata,
               {~POL, ~POL, 3'b000});
    end
    step(1, 0, 1);
    n_run++;
    if ({rd_seen, vsync, hsync, de, falign, underflow} !== {1'b0, ~POL, ~POL, 3'b000}) begin
      n_fail++;
      $display("FAIL reset2 got %b want %b", {rd_seen, vsync, hsync, de, falign, underflow},
               {1'b0, ~POL, ~POL, 3'b000});
    end
`ifdef NATIVE_OUT_UNDERFLOW_CNT_EN
    n_run++;
    if (underflow_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d want 0", underflow_cnt);
    end
`endif
  endtask

  task automatic test_frame();
    int last, pops;
    bit seen;
    seen = 0; pops = 0; last = 0;
    in_cfg = t1_cfg();
    step(1, 0, 1);
    for (int i = 0; i < 160; i++) begin
      step(0, 1, 1);
      n_run++;
      if ({rd_seen, vsync, hsync, de, falign, underflow, odata} !==
          {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf, exp_od}) begin
        n_fail++;
        $display("FAIL frame cyc%0d got %b_%h want %b_%h", i,
                 {rd_seen, vsync, hsync, de, falign, underflow}, odata,
                 {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf}, exp_od);
      end
      if (falign) begin
        if (seen) begin
          n_run++;
          if (i - last != 48 || pops != 12) begin
            n_fail++;
            $display("FAIL frame_len got %0d/%0d pops want 48/12", i - last, pops);
          end
        end
        seen = 1; last = i; pops = 0;
      end
      if (rd_seen) pops++;
    end
  endtask

  task automatic test_underflow_fixed();
    logic v;
    in_cfg = t1_cfg();
    step(1, 0, 1);
    for (int i = 0; i < 110; i++) begin
      v = !(m_run && i < 40 && (m_p == 19 || m_p == 20));
      step(0, 1, v);
      n_run++;
      if ({rd_seen, vsync, hsync, de, falign, underflow, odata} !==
          {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf, exp_od}) begin
        n_fail++;
        $display("FAIL uflow cyc%0d got %b_%h want %b_%h", i,
                 {rd_seen, vsync, hsync, de, falign, underflow}, odata,
                 {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf}, exp_od);
      end
      if (i == 30) begin
        n_run++;
        if (underflow !== 1'b1) begin
          n_fail++;
          $display("FAIL uflow_sticky got %b want 1", underflow);
        end
      end
    end
`ifdef NATIVE_OUT_UNDERFLOW_CNT_EN
    n_run++;
    if (underflow_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL uflow_cnt got %0d want 2", underflow_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      in_cfg.hsw = $urandom_range(0, 3);
      in_cfg.hbp = $urandom_range(0, 2);
      in_cfg.ha  = $urandom_range(0, 5);
      in_cfg.hfp = $urandom_range(0, 2);
      in_cfg.vsw = $urandom_range(0, 2);
      in_cfg.vbp = $urandom_range(0, 2);
      in_cfg.va  = $urandom_range(0, 4);
      in_cfg.vfp = $urandom_range(0, 2);
      step(1, 0, 1);
      for (int i = 0; i < 200; i++) begin
        step(0, 1, $urandom_range(0, 3) != 0);
        n_run++;
        if ({rd_seen, vsync, hsync, de, falign, underflow, odata} !==
            {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf, exp_od}) begin
          n_fail++;
          $display("FAIL rand%0d cyc%0d got %b_%h want %b_%h", k, i,
                   {rd_seen, vsync, hsync, de, falign, underflow}, odata,
                   {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf}, exp_od);
        end
      end
`ifdef NATIVE_OUT_UNDERFLOW_CNT_EN
      n_run++;
      if (underflow_cnt !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt got %0d want %0d", underflow_cnt, m_cnt);
      end
`endif
    end
  endtask

  task automatic test_enable_drop();
    logic en;
    in_cfg = t1_cfg();
    step(1, 0, 1);
    for (int i = 0; i < 140; i++) begin
      en = !(i >= 30 && i < 100);
      step(0, en, 1);
      n_run++;
      if ({rd_seen, vsync, hsync, de, falign, underflow, odata} !==
          {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf, exp_od}) begin
        n_fail++;
        $display("FAIL endrop cyc%0d got %b_%h want %b_%h", i,
                 {rd_seen, vsync, hsync, de, falign, underflow}, odata,
                 {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf}, exp_od);
      end
      if (i == 60 || i == 99) begin
        n_run++;
        if ({vsync, hsync, de, rd_seen} !== {~POL, ~POL, 2'b00}) begin
          n_fail++;
          $display("FAIL endrop_idle cyc%0d got %b want %b", i, {vsync, hsync, de, rd_seen},
                   {~POL, ~POL, 2'b00});
        end
      end
      if (i == 101) begin
        n_run++;
        if (falign !== 1'b1) begin
          n_fail++;
          $display("FAIL endrop_restart got %b want 1", falign);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic r;
    in_cfg = t1_cfg();
    step(1, 0, 1);
    for (int i = 0; i < 40; i++) begin
      r = (i == 20);
      step(r, i < 20, 1);
      n_run++;
      if ({rd_seen, vsync, hsync, de, falign, underflow, odata} !==
          {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf, exp_od}) begin
        n_fail++;
        $display("FAIL rstmid cyc%0d got %b_%h want %b_%h", i,
                 {rd_seen, vsync, hsync, de, falign, underflow}, odata,
                 {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf}, exp_od);
      end
      if (i == 20) begin
        n_run++;
        if ({vsync, hsync, de, falign, underflow, idata_rd} !== {~POL, ~POL, 4'b0000}) begin
          n_fail++;
          $display("FAIL rstmid_now got %b want %b", {vsync, hsync, de, falign, underflow, idata_rd},
                   {~POL, ~POL, 4'b0000});
        end
      end
    end
  endtask

  task automatic test_timing_change();
    int last, n;
    last = 0; n = 0;
    in_cfg = t1_cfg();
    step(1, 0, 1);
    for (int i = 0; i < 180; i++) begin
      if (i == 10) in_cfg.ha = 6;
      step(0, 1, 1);
      n_run++;
      if ({rd_seen, vsync, hsync, de, falign, underflow, odata} !==
          {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf, exp_od}) begin
        n_fail++;
        $display("FAIL tchg cyc%0d got %b_%h want %b_%h", i,
                 {rd_seen, vsync, hsync, de, falign, underflow}, odata,
                 {exp_rd, exp_vs, exp_hs, exp_de, exp_fa, exp_uf}, exp_od);
      end
      if (falign) begin
        if (n == 1 || n == 2) begin
          n_run++;
          if (i - last != (n == 1 ? 48 : 60)) begin
            n_fail++;
            $display("FAIL tchg_len%0d got %0d want %0d", n, i - last, n == 1 ? 48 : 60);
          end
        end
        n++; last = i;
      end
    end
  endtask

  task automatic test_illegal();
    in_cfg = '{hsw: 0, hbp: 0, ha: 1, hfp: 0, vsw: 1, vbp: 0, va: 1, vfp: 0};
    step(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1);
      n_run++;
      if ({rd_seen, vsync, hsync, de, falign} !== {1'b0, ~POL, ~POL, 2'b00}) begin
        n_fail++;
        $display("FAIL illegal cyc%0d got %b want %b", i, {rd_seen, vsync, hsync, de, falign},
                 {1'b0, ~POL, ~POL, 2'b00});
      end
    end
  endtask

  initial begin
    m_run = 0; m_p = 0; m_uf = 0; m_cnt = 0;
    m_cfg = '{default: 0};
    rst = 1; enable = 0; idata = '0; idata_vld = 0;
    test_reset();
    test_frame();
    test_underflow_fixed();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_timing_change();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
